step_clock_ctrl: RTL and testbench
==================================

// Module: step_clock_ctrl
// PURPOSE
//   Upstream execution-pacing stage for the Zepto processor core. Produces a
//   one-cycle step_en strobe that the PC, register file and control path use
//   as their advance enable. Everything runs on one free-running clk.
//   Two step sources: an auto-run divider, or a debounced manual pushbutton.
//   Replaces combinational clock muxing with a single clock domain.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000    consecutive stable cycles required to accept a button edge (>=2)
//   AUTO_DIV         25000000  clk cycles per auto-run step (>=2)
//   SYNC_STAGES      2         flip-flop depth of input synchronisers (>=2)
// PORTS
//   clk         in   1   system clock (board oscillator)
//   Reset       in   1   synchronous, active-high reset
//   key_n       in   1   raw pushbutton, active-low, asynchronous, bouncy
//   run_mode    in   1   raw slide switch, asynchronous: 0 = auto-run, 1 = manual step
//   halt        in   1   synchronous to clk; 1 = freeze auto-run (e.g. halt instruction)
//   step_en     out  1   one-cycle step strobe to the core
//   key_level   out  1   debounced button state, 1 = pressed
//   manual_act  out  1   effective (synchronised) mode, 1 = manual
// BEHAVIOUR
//   Reset (sampled on a clk edge)
//   - step_en=0, key_level=0, manual_act=0; FSM=IDLE; all counters=0.
//   - Synchroniser flops reset to the inactive value (key released, auto mode).
//   Synchronisers
//   - key_n and run_mode each pass through SYNC_STAGES flops before use.
//   - halt is used directly.
//   Debounce FSM on the synchronised key (pressed = ~key_sync); four states:
//   - IDLE: go to PRESS_WAIT when pressed; clear cnt.
//   - PRESS_WAIT: cnt++ while pressed; return to IDLE on release (bounce).
//     When cnt reaches DEBOUNCE_CYCLES-1, go to HELD.
//   - HELD: key_level=1; go to RELEASE_WAIT on release; clear cnt.
//   - RELEASE_WAIT: cnt++ while released; return to HELD on press.
//     When cnt reaches DEBOUNCE_CYCLES-1, go to IDLE and set key_level=0.
//   - The FSM runs in both modes; key_level is always valid.
//   Manual step
//   - step_en=1 for exactly one cycle on the PRESS_WAIT->HELD transition, only when manual_act=1.
//   - Latency: with a raw falling edge at cycle 0 and clean input, step_en is high in
//     cycle SYNC_STAGES+DEBOUNCE_CYCLES.
//   - Releasing never generates a step.
//   - Holding the button gives exactly one step (no auto-repeat).
//   Auto step (manual_act=0)
//   - div counts 0..AUTO_DIV-1 and wraps.
//   - step_en=1 in the cycle where div==AUTO_DIV-1.
//   - halt=1: div is held at 0 and no step is produced.
//   - After halt falls, the first step comes on the AUTO_DIV-th cycle with halt low.
//   Mode change
//   - When synchronised run_mode differs from manual_act: update manual_act and clear div.
//   - step_en is forced 0 in that cycle.
//   - Debounce FSM state is kept, so a press already HELD does not step on entering manual.
//   Invariants
//   - step_en is never high in two consecutive cycles.
//   - Only one source is active at a time, so the two sources never collide.
//   - div is 0 whenever manual_act=1.
//   Reset mid-operation
//   - Reset returns the FSM to IDLE.
//   - A key still held after Reset is treated as a fresh press: one step after
//     SYNC_STAGES+DEBOUNCE_CYCLES.
// CONFIGURATION
//   STEP_COUNT_EN
//   - Defined: adds port step_count out 16, counting step_en pulses.
//     Reset value 0; wraps 0xFFFF->0x0000; increments in the cycle after each step_en.
//   - Undefined: the port and counter are absent; all other behaviour is identical.
// TESTING (DEBOUNCE_CYCLES=4, AUTO_DIV=5, SYNC_STAGES=2, STEP_COUNT_EN defined)
//   1. Reset held 3 cycles, key_n=1, run_mode=0 -> step_en=0, key_level=0, manual_act=0, step_count=0.
//   2. Auto, halt=0, 20 cycles after reset -> step_en pulses at div==4 (every 5 cycles),
//      each 1 cycle wide; step_count=4.
//   3. run_mode=1, settle; key_n low at cycle 0 for 12 cycles -> one step_en at cycle 6;
//      key_level=1; release -> no pulse; key_level=0 at 6 cycles after release.
//   4. Manual; key_n toggles every 2 cycles for 12 cycles, then held low -> exactly one
//      step_en, 6 cycles after the last falling edge.
//   5. Auto; halt=1 for 12 cycles mid-count -> no step_en; halt=0 -> first step_en
//      5 cycles later.
//   6. Manual, key held in HELD, Reset pulsed 1 cycle, key still low -> outputs 0;
//      one step_en 6 cycles after Reset drops.

Source files
------------

// File: rtl/step_clock_ctrl_if.sv
// Control/status bundle for step_clock_ctrl: raw operator inputs, halt request and step outputs.
// Optional macro STEP_COUNT_EN adds the 16-bit step_count status signal.
interface step_clock_ctrl_if;
  logic        key_n;
  logic        run_mode;
  logic        halt;
  logic        step_en;
  logic        key_level;
  logic        manual_act;
`ifdef STEP_COUNT_EN
  logic [15:0] step_count;

  modport master (
    output key_n, run_mode, halt,
    input  step_en, key_level, manual_act, step_count
  );

  modport slave (
    input  key_n, run_mode, halt,
    output step_en, key_level, manual_act, step_count
  );
`else
  modport master (
    output key_n, run_mode, halt,
    input  step_en, key_level, manual_act
  );

  modport slave (
    input  key_n, run_mode, halt,
    output step_en, key_level, manual_act
  );
`endif
endinterface

// File: rtl/step_clock_ctrl.sv
// Execution-pacing stage: generates a one-cycle step_en strobe from either an auto-run divider
// or a debounced manual pushbutton, all in the single clk domain.
// Optional macro STEP_COUNT_EN adds a 16-bit wrapping count of step_en pulses.
module step_clock_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_DIV        = 25000000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               Reset,
  step_clock_ctrl_if.slave   bus
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned DivW = $clog2(AUTO_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0] DivMax = DivW'(AUTO_DIV - 1);

  typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} db_state_e;

  logic [SYNC_STAGES-1:0] key_sync_q;
  logic [SYNC_STAGES-1:0] run_sync_q;
  logic                   pressed;
  logic                   run_sync;

  db_state_e              state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DivW-1:0]        div_q, div_d;
  logic                   manual_act_q;
  logic                   mode_change;
  logic                   step_en;

  // Input synchronisers; reset to "key released, auto mode".
  always_ff @(posedge clk) begin
    if (Reset) begin
      key_sync_q <= '1;
      run_sync_q <= '0;
    end else begin
      key_sync_q <= {key_sync_q[SYNC_STAGES-2:0], bus.key_n};
      run_sync_q <= {run_sync_q[SYNC_STAGES-2:0], bus.run_mode};
    end
  end

  assign pressed     = ~key_sync_q[SYNC_STAGES-1];
  assign run_sync    = run_sync_q[SYNC_STAGES-1];
  assign mode_change = (run_sync != manual_act_q);

  // Debounce FSM next state; a bounce returns to the stable state it came from.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (pressed) state_d = StPressWait;
      end
      StPressWait: begin
        if (!pressed) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d = StHeld;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!pressed) state_d = StReleaseWait;
      end
      StReleaseWait: begin
        if (pressed) begin
          state_d = StHeld;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Auto-run divider next state; held at zero in manual mode, on halt and on a mode change.
  always_comb begin
    div_d = '0;
    if (!mode_change && !manual_act_q && !bus.halt && (div_q != DivMax)) begin
      div_d = div_q + 1'b1;
    end
  end

  // Step strobe: only the source selected by the settled mode may fire.
  always_comb begin
    step_en = 1'b0;
    if (!mode_change) begin
      if (manual_act_q) begin
        step_en = (state_q == StPressWait) && (state_d == StHeld);
      end else begin
        step_en = !bus.halt && (div_q == DivMax);
      end
    end
  end

  // State, counters and effective mode.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      div_q        <= '0;
      manual_act_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      manual_act_q <= run_sync;
    end
  end

  assign bus.step_en    = step_en;
  // key_level follows the debounced decision in the cycle it is made.
  assign bus.key_level  = (state_d == StHeld) || (state_d == StReleaseWait);
  assign bus.manual_act = manual_act_q;

`ifdef STEP_COUNT_EN
  logic [15:0] step_count_q;

  // Count of issued steps, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (Reset) begin
      step_count_q <= '0;
    end else if (step_en) begin
      step_count_q <= step_count_q + 16'd1;
    end
  end

  assign bus.step_count = step_count_q;
`endif

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Directed self-checking bench for step_clock_ctrl (DEBOUNCE_CYCLES=4, AUTO_DIV=5, SYNC_STAGES=2).
// Inputs are driven and outputs sampled on the falling edge; cycle k follows rising edge k.
module tb_step_clock_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  step_clock_ctrl_if bus ();

  step_clock_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_DIV       (5),
    .SYNC_STAGES    (2)
  ) dut (
    .clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst          = 1'b1;
    bus.key_n    = 1'b1;
    bus.run_mode = 1'b0;
    bus.halt     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.step_en !== 1'b0) begin
      errors++; $display("FAIL reset_step_en got %b want 0", bus.step_en);
    end
    checks++;
    if (bus.key_level !== 1'b0) begin
      errors++; $display("FAIL reset_key_level got %b want 0", bus.key_level);
    end
    checks++;
    if (bus.manual_act !== 1'b0) begin
      errors++; $display("FAIL reset_manual_act got %b want 0", bus.manual_act);
    end
`ifdef STEP_COUNT_EN
    checks++;
    if (bus.step_count !== 16'd0) begin
      errors++; $display("FAIL reset_step_count got %0d want 0", bus.step_count);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_auto();
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (bus.step_en !== ((k % 5) == 4)) begin
        errors++; $display("FAIL auto_step cycle %0d got %b want %b", k, bus.step_en, (k % 5) == 4);
      end
      @(negedge clk);
    end
`ifdef STEP_COUNT_EN
    checks++;
    if (bus.step_count !== 16'd4) begin
      errors++; $display("FAIL auto_step_count got %0d want 4", bus.step_count);
    end
`endif
  endtask

  task automatic test_manual_press();
    logic [15:0] base;
    base = 16'd0;
    bus.run_mode = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.manual_act !== 1'b1) begin
      errors++; $display("FAIL manual_act_enter got %b want 1", bus.manual_act);
    end
`ifdef STEP_COUNT_EN
    base = bus.step_count;
`endif
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (bus.step_en !== (k == 6)) begin
        errors++; $display("FAIL press_step cycle %0d got %b want %b", k, bus.step_en, k == 6);
      end
      checks++;
      if (bus.key_level !== (k >= 6)) begin
        errors++; $display("FAIL press_key_level cycle %0d got %b want %b", k, bus.key_level, k >= 6);
      end
      if (k == 0) bus.key_n = 1'b0;
      @(negedge clk);
    end
    for (int r = 0; r < 10; r++) begin
      checks++;
      if (bus.step_en !== 1'b0) begin
        errors++; $display("FAIL release_step cycle %0d got %b want 0", r, bus.step_en);
      end
      checks++;
      if (bus.key_level !== (r < 6)) begin
        errors++; $display("FAIL release_key_level cycle %0d got %b want %b", r, bus.key_level, r < 6);
      end
      if (r == 0) bus.key_n = 1'b1;
      @(negedge clk);
    end
`ifdef STEP_COUNT_EN
    checks++;
    if (bus.step_count !== base + 16'd1) begin
      errors++; $display("FAIL press_step_count got %0d want %0d", bus.step_count, base + 16'd1);
    end
`endif
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 25; k++) begin
      checks++;
      if (bus.step_en !== (k == 18)) begin
        errors++; $display("FAIL bounce_step cycle %0d got %b want %b", k, bus.step_en, k == 18);
      end
      checks++;
      if (bus.key_level !== (k >= 18)) begin
        errors++; $display("FAIL bounce_key_level cycle %0d got %b want %b", k, bus.key_level, k >= 18);
      end
      bus.key_n = (k < 12) ? (((k / 2) % 2) == 1) : 1'b0;
      @(negedge clk);
    end
    bus.key_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.key_level !== 1'b0) begin
      errors++; $display("FAIL bounce_released_key_level got %b want 0", bus.key_level);
    end
  endtask

  task automatic test_halt();
    bus.run_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.manual_act !== 1'b0) begin
      errors++; $display("FAIL manual_act_leave got %b want 0", bus.manual_act);
    end
    for (int a = 0; a < 28; a++) begin
      checks++;
      if (bus.step_en !== (a == 4 || a == 22 || a == 27)) begin
        errors++;
        $display("FAIL halt_step cycle %0d got %b want %b", a, bus.step_en,
                 a == 4 || a == 22 || a == 27);
      end
      if (a == 6)  bus.halt = 1'b1;
      if (a == 18) bus.halt = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bus.run_mode = 1'b1;
    repeat (4) @(negedge clk);
    bus.key_n = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.key_level !== 1'b1) begin
      errors++; $display("FAIL held_key_level got %b want 1", bus.key_level);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.step_en !== 1'b0) begin
      errors++; $display("FAIL midreset_step_en got %b want 0", bus.step_en);
    end
    checks++;
    if (bus.key_level !== 1'b0) begin
      errors++; $display("FAIL midreset_key_level got %b want 0", bus.key_level);
    end
    checks++;
    if (bus.manual_act !== 1'b0) begin
      errors++; $display("FAIL midreset_manual_act got %b want 0", bus.manual_act);
    end
`ifdef STEP_COUNT_EN
    checks++;
    if (bus.step_count !== 16'd0) begin
      errors++; $display("FAIL midreset_step_count got %0d want 0", bus.step_count);
    end
`endif
    rst = 1'b0;
    for (int q = 0; q < 13; q++) begin
      checks++;
      if (bus.step_en !== (q == 6)) begin
        errors++; $display("FAIL postreset_step cycle %0d got %b want %b", q, bus.step_en, q == 6);
      end
      checks++;
      if (bus.key_level !== (q >= 6)) begin
        errors++;
        $display("FAIL postreset_key_level cycle %0d got %b want %b", q, bus.key_level, q >= 6);
      end
      @(negedge clk);
    end
`ifdef STEP_COUNT_EN
    checks++;
    if (bus.step_count !== 16'd1) begin
      errors++; $display("FAIL postreset_step_count got %0d want 1", bus.step_count);
    end
`endif
    bus.key_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_auto();
    test_manual_press();
    test_bounce();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
